// File: rtl/bus_pkg.sv
// Shared types and default sizing for the system bus arbiter.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   localparam int unsigned DEF_NUM_MASTERS = 4;
   localparam int unsigned DEF_TIMEOUT     = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration and shared-strobe signals of the system bus.
// slave: the arbiter's view; master: the bus agents' view.
interface bus_arbiter_if import bus_pkg::*; #(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
);
   localparam int unsigned OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] bus_req;
   logic [NUM_MASTERS-1:0] bus_grant;
   logic                   rd_bus;
   logic                   wr_bus;
   logic                   fc_bus;
   logic                   watchdog;
   logic [OW-1:0]          owner;
   logic                   busy;

   modport master (
      output bus_req, rd_bus, wr_bus, fc_bus,
      input  bus_grant, watchdog, owner, busy
   );

   modport slave (
      input  bus_req, rd_bus, wr_bus, fc_bus,
      output bus_grant, watchdog, owner, busy
   );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Rotating-priority request picker: the first set request at or after
// ptr, wrapping from N-1 back to 0, wins.
module rr_picker import bus_pkg::*; #(
   parameter int unsigned N  = DEF_NUM_MASTERS,
   parameter int unsigned PW = $clog2(DEF_NUM_MASTERS)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   // Scan upward from ptr; the first requester seen takes the grant.
   always_comb begin
      logic [PW-1:0] idx;
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PW'((32'(ptr) + i) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter: non-preemptive tenures, a one-cycle
// turnaround between grants and a watchdog that aborts stalled transfers.
module bus_arbiter import bus_pkg::*; #(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   bus_arbiter_if.slave bus
);

   localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   arb_state_e             state_q, state_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [PW-1:0]          owner_q, owner_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic                   wd_q, wd_d;
   logic                   busy_q, busy_d;

   logic [NUM_MASTERS-1:0] pick;
   logic                   pick_valid;
   logic [PW-1:0]          pick_idx;
   logic [PW-1:0]          next_ptr;
   logic                   stall;
   logic                   timeout;

   rr_picker #(
      .N  (NUM_MASTERS),
      .PW (PW)
   ) u_picker (
      .req    (bus.bus_req),
      .ptr    (ptr_q),
      .winner (pick),
      .valid  (pick_valid)
   );

   // A transfer stalls when exactly one strobe is up and no acknowledge.
   assign stall    = (bus.rd_bus ^ bus.wr_bus) & ~bus.fc_bus;
   assign timeout  = stall && (cnt_q == CW'(TIMEOUT - 1));
   assign next_ptr = PW'((32'(owner_q) + 1) % NUM_MASTERS);

   // Convert the picker's one-hot winner into an owner index.
   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (pick[i]) pick_idx = PW'(i);
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = '0;
      grant_d = grant_q;
      wd_d    = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = GRANTED;
               grant_d = pick;
               owner_d = pick_idx;
               busy_d  = 1'b1;
            end
         end
         GRANTED: begin
            // Timeout takes priority over a simultaneous request drop,
            // so the abort pulse is never lost.
            if (timeout || !bus.bus_req[owner_q]) begin
               state_d = RELEASE;
               wd_d    = timeout;
               grant_d = '0;
               owner_d = '0;
               busy_d  = 1'b0;
               ptr_d   = next_ptr;
            end else if (stall) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         wd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         wd_q    <= wd_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.bus_grant = grant_q;
   assign bus.watchdog  = wd_q;
   assign bus.owner     = owner_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a
// randomized run scored against a tenure-level reference model.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

   bus_arbiter #(
      .NUM_MASTERS (N),
      .TIMEOUT     (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_time_limit: run did not complete, limit 1000000 reached");
      $fatal(1);
   end

   // Reference model: who holds the bus, turnaround cycles left, the
   // master with top priority next, and the length of the current stall.
   int m_holder;
   int m_cool;
   int m_ptr;
   int m_stall;
   bit m_wd;

   function automatic void model_reset();
      m_holder = -1;
      m_cool   = 0;
      m_ptr    = 0;
      m_stall  = 0;
      m_wd     = 1'b0;
   endfunction

   function automatic void model_edge(logic [N-1:0] req, logic rd, logic wr, logic fc);
      m_wd = 1'b0;
      if (m_holder >= 0) begin
         m_stall = ((rd != wr) && !fc) ? m_stall + 1 : 0;
         if (m_stall >= TO || !req[2'(m_holder)]) begin
            m_wd     = (m_stall >= TO);
            m_ptr    = (m_holder + 1) % N;
            m_holder = -1;
            m_cool   = 1;
            m_stall  = 0;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (m_holder < 0 && req[2'((m_ptr + k) % N)]) m_holder = (m_ptr + k) % N;
         end
      end
   endfunction

   // {grant, owner, busy, watchdog}
   function automatic logic [7:0] model_out();
      logic [N-1:0] g;
      logic [1:0]   o;
      g = '0;
      o = '0;
      if (m_holder >= 0) begin
         g = 4'(1 << m_holder);
         o = 2'(m_holder);
      end
      return {g, o, (m_holder >= 0), m_wd};
   endfunction

   task automatic drive_idle();
      bus.bus_req = '0;
      bus.rd_bus  = 1'b0;
      bus.wr_bus  = 1'b0;
      bus.fc_bus  = 1'b0;
   endtask

   // Advance one clock; inputs are applied 1ns after an edge, outputs read 1ns after.
   task automatic step();
      @(posedge clk);
      model_edge(bus.bus_req, bus.rd_bus, bus.wr_bus, bus.fc_bus);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b expected 0000", bus.bus_grant); end
      n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.watchdog !== 1'b0) begin n_bad++; $display("FAIL reset_watchdog: got %b expected 0", bus.watchdog); end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step();
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: busy got %b expected 0", bus.busy); end
   endtask

   task automatic test_single();
      do_reset();
      bus.bus_req = 4'b0100;
      step();
      n_cmp++; if (bus.bus_grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b expected 0100", bus.bus_grant); end
      n_cmp++; if (bus.owner !== 2'd2) begin n_bad++; $display("FAIL single_owner: got %0d expected 2", bus.owner); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
      bus.bus_req = 4'b0000;
      step();
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL single_release: got %b expected 0000", bus.bus_grant); end
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      do_reset();
      bus.bus_req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         exp = 4'(1 << (k % 4));
         n_cmp++; if (bus.bus_grant !== exp) begin n_bad++; $display("FAIL rr_grant%0d: got %b expected %b", k, bus.bus_grant, exp); end
         step();
         step();
         n_cmp++; if (bus.bus_grant !== exp) begin n_bad++; $display("FAIL rr_hold%0d: got %b expected %b", k, bus.bus_grant, exp); end
         bus.bus_req = bus.bus_req & ~exp;
         step();
         n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL rr_clear%0d: got %b expected 0000", k, bus.bus_grant); end
         bus.bus_req = 4'b1111;
         step();
         n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL rr_turnaround%0d: got %b expected 0000", k, bus.bus_grant); end
         step();
      end
      bus.bus_req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_watchdog();
      do_reset();
      bus.bus_req = 4'b0010;
      step();
      n_cmp++; if (bus.bus_grant !== 4'b0010) begin n_bad++; $display("FAIL wd_grant: got %b expected 0010", bus.bus_grant); end
      bus.bus_req = 4'b0110;
      bus.rd_bus  = 1'b1;
      for (int i = 1; i < TO; i++) begin
         step();
         n_cmp++;
         if (bus.watchdog !== 1'b0 || bus.bus_grant !== 4'b0010) begin
            n_bad++; $display("FAIL wd_early%0d: wd=%b grant=%b expected wd=0 grant=0010", i, bus.watchdog, bus.bus_grant);
         end
      end
      step();
      n_cmp++; if (bus.watchdog !== 1'b1) begin n_bad++; $display("FAIL wd_pulse: got %b expected 1", bus.watchdog); end
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL wd_grant_clear: got %b expected 0000", bus.bus_grant); end
      step();
      n_cmp++; if (bus.watchdog !== 1'b0) begin n_bad++; $display("FAIL wd_one_cycle: got %b expected 0", bus.watchdog); end
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL wd_turnaround: got %b expected 0000", bus.bus_grant); end
      step();
      n_cmp++; if (bus.bus_grant !== 4'b0100) begin n_bad++; $display("FAIL wd_next_grant: got %b expected 0100", bus.bus_grant); end
      n_cmp++; if (bus.owner !== 2'd2) begin n_bad++; $display("FAIL wd_next_owner: got %0d expected 2", bus.owner); end
      drive_idle();
      step();
      step();
   endtask

   task automatic test_fc_wins();
      do_reset();
      bus.bus_req = 4'b0010;
      step();
      bus.bus_req = 4'b0110;
      bus.rd_bus  = 1'b1;
      repeat (TO - 1) step();
      bus.fc_bus = 1'b1;
      step();
      n_cmp++; if (bus.watchdog !== 1'b0) begin n_bad++; $display("FAIL fc_no_wd: got %b expected 0", bus.watchdog); end
      n_cmp++; if (bus.bus_grant !== 4'b0010) begin n_bad++; $display("FAIL fc_hold: got %b expected 0010", bus.bus_grant); end
      bus.fc_bus = 1'b0;
      for (int i = 1; i < TO; i++) begin
         step();
         n_cmp++;
         if (bus.watchdog !== 1'b0 || bus.bus_grant !== 4'b0010) begin
            n_bad++; $display("FAIL fc_restart%0d: wd=%b grant=%b expected wd=0 grant=0010", i, bus.watchdog, bus.bus_grant);
         end
      end
      step();
      n_cmp++; if (bus.watchdog !== 1'b1) begin n_bad++; $display("FAIL fc_restart_wd: got %b expected 1", bus.watchdog); end
      drive_idle();
      step();
      step();
   endtask

   task automatic test_both_strobes();
      do_reset();
      bus.bus_req = 4'b0001;
      step();
      bus.rd_bus = 1'b1;
      bus.wr_bus = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         n_cmp++;
         if (bus.watchdog !== 1'b0 || bus.bus_grant !== 4'b0001) begin
            n_bad++; $display("FAIL both_strobes%0d: wd=%b grant=%b expected wd=0 grant=0001", i, bus.watchdog, bus.bus_grant);
         end
      end
      drive_idle();
      step();
      step();
   endtask

   task automatic test_rst_mid();
      do_reset();
      bus.bus_req = 4'b1000;
      step();
      n_cmp++; if (bus.owner !== 2'd3) begin n_bad++; $display("FAIL rst_mid_owner: got %0d expected 3", bus.owner); end
      bus.rd_bus = 1'b1;
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL rst_async_grant: got %b expected 0000", bus.bus_grant); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b expected 0", bus.busy); end
      n_cmp++; if (bus.watchdog !== 1'b0) begin n_bad++; $display("FAIL rst_async_wd: got %b expected 0", bus.watchdog); end
      model_reset();
      bus.rd_bus  = 1'b0;
      bus.bus_req = 4'b1001;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.bus_grant !== 4'b0000) begin n_bad++; $display("FAIL rst_held: got %b expected 0000", bus.bus_grant); end
      rst = 1'b0;
      step();
      n_cmp++; if (bus.bus_grant !== 4'b0001) begin n_bad++; $display("FAIL rst_prio0: got %b expected 0001", bus.bus_grant); end
      drive_idle();
      step();
      step();
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [7:0]   got;
      logic [7:0]   exp;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         r = bus.bus_req;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5) == 0) r = r ^ 4'(1 << i);
         end
         bus.bus_req = r;
         bus.rd_bus  = ($urandom_range(9) != 0);
         bus.wr_bus  = ($urandom_range(7) == 0);
         bus.fc_bus  = ($urandom_range(19) == 0);
         step();
         got = {bus.bus_grant, bus.owner, bus.busy, bus.watchdog};
         exp = model_out();
         n_cmp++;
         if (got !== exp) begin
            n_bad++; $display("FAIL rand_cycle%0d: got grant/owner/busy/wd=%b expected %b", c, got, exp);
         end
      end
      drive_idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_watchdog();
      test_fc_wins();
      test_both_strobes();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters sharing the system bus.
REQ-002 SHALL have parameter TIMEOUT, default 16, number of cycles a transfer may wait for fc_bus before the watchdog fires.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bus_req  input  NUM_MASTERS  per-master bus request; bit i from master i.
REQ-006 SHALL have port bus_grant  output  NUM_MASTERS  per-master grant; one-hot or zero.
REQ-007 SHALL have port rd_bus  input  1  shared read strobe.
REQ-008 SHALL have port wr_bus  input  1  shared write strobe.
REQ-009 SHALL have port fc_bus  input  1  shared function-complete/acknowledge from the addressed slave.
REQ-010 SHALL have port watchdog  output  1  one-cycle abort pulse, broadcast to all masters.
REQ-011 SHALL have port owner  output  clog2(NUM_MASTERS)  index of the current grantee; 0 when no grant.
REQ-012 SHALL have port busy  output  1  high while any grant is asserted.

Function
REQ-013 SHALL implement states IDLE, GRANTED and RELEASE; all outputs SHALL be registered.
REQ-014 IDLE: if bus_req is nonzero, SHALL select the first set bit at or after the round-robin pointer ptr, wrapping from NUM_MASTERS-1 to 0, then assert that grant bit and enter GRANTED on the next edge.
REQ-015 Grant latency SHALL be 1 cycle: bus_req sampled in IDLE at edge t gives bus_grant high from edge t+1.
REQ-016 GRANTED: the grant SHALL be held unchanged while bus_req[owner] stays high; requests from other masters SHALL be ignored (no preemption).
REQ-017 GRANTED: when bus_req[owner] is low, bus_grant SHALL clear on the next edge, the FSM SHALL enter RELEASE, and ptr SHALL be set to (owner+1) mod NUM_MASTERS.
REQ-018 RELEASE: SHALL last exactly 1 cycle with bus_grant = 0 (tri-state turnaround), then return to IDLE unconditionally; the earliest new grant is 2 cycles after the grant clears.
REQ-019 A transfer is active when rd_bus XOR wr_bus is 1; rd_bus = wr_bus = 1 SHALL be treated as no transfer.
REQ-020 Watchdog counter, width clog2(TIMEOUT+1): SHALL increment each GRANTED cycle with an active transfer and fc_bus low; SHALL clear when fc_bus is high, when no transfer is active, or when the FSM is outside GRANTED.
REQ-021 When the counter reaches TIMEOUT, watchdog SHALL pulse high for exactly 1 cycle, bus_grant SHALL clear on the same edge, the FSM SHALL enter RELEASE, and ptr SHALL advance as in REQ-017.
REQ-022 If fc_bus is high on the same cycle the counter would reach TIMEOUT, fc_bus SHALL win: no watchdog pulse and the counter clears.
REQ-023 If bus_req[owner] drops on the same cycle as a timeout, the FSM SHALL take the REQ-021 path and watchdog SHALL pulse.
REQ-024 owner SHALL be the index of the set bus_grant bit; busy SHALL equal OR(bus_grant).

Reset
REQ-025 On rst, the block SHALL asynchronously set state = IDLE, bus_grant = 0, watchdog = 0, owner = 0, busy = 0, ptr = 0, counter = 0.
REQ-026 An rst asserted mid-tenure SHALL drop the grant immediately, with no watchdog pulse and no RELEASE cycle.
REQ-027 The first arbitration after rst deasserts SHALL give master 0 the highest priority.

Structure
REQ-028 The shared package bus_pkg SHALL hold the state encoding (IDLE/GRANTED/RELEASE) and the default NUM_MASTERS and TIMEOUT constants.
REQ-029 One combinational sub-module, rr_picker (inputs: request vector and ptr; outputs: one-hot winner and valid), SHALL perform the rotating priority selection.

Verification
REQ-030 Scenario: rst, then bus_req = 4'b0100 -> bus_grant = 4'b0100 one cycle later; owner = 2; busy = 1.
REQ-031 Scenario: bus_req = 4'b1111 held; each master drops its request after 3 granted cycles and immediately re-requests -> grant order 0, 1, 2, 3, 0, with 1 RELEASE cycle between tenures.
REQ-032 Scenario: master 1 granted, rd_bus = 1, fc_bus held low -> watchdog pulses for 1 cycle after 16 stalled cycles, bus_grant clears on the same edge, and master 2's pending request is granted 2 cycles later.
REQ-033 Scenario: same as REQ-032 but fc_bus pulses on stall cycle 16 -> no watchdog pulse; the grant is held.
REQ-034 Scenario: rd_bus = wr_bus = 1 for 40 cycles while granted -> no watchdog pulse.
REQ-035 Scenario: rst pulsed while master 3 is granted mid-transfer -> bus_grant = 0 asynchronously; after release, bus_req = 4'b1001 -> master 0 granted.
